// File: rtl/pfgen_stride_pkg.sv
// Shared types and constants for the PC-indexed stride prefetch generator.
package pfgen_stride_pkg;

    localparam int unsigned PC_BITS        = 48;
    localparam int unsigned LADDR_BITS     = 44;
    localparam int unsigned STRIDE_BITS    = 12;
    localparam int unsigned CONF_BITS      = 2;
    localparam int unsigned PFGEN_TAG_BITS = 10;
    localparam int unsigned PF_PAGE_SHIFT  = 6;

    // Prefetch op handed to the prefetch engine.
    typedef struct packed {
        logic [LADDR_BITS-1:0] laddr;
        logic                  l2only;
    } I_pfgtopfe_op_type;

    // One stride-table entry; stride is a two's-complement line count.
    typedef struct packed {
        logic                      valid;
        logic [PFGEN_TAG_BITS-1:0] tag;
        logic [LADDR_BITS-1:0]     last;
        logic [STRIDE_BITS-1:0]    stride;
        logic [CONF_BITS-1:0]      conf;
    } pfgen_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } pfgen_state_e;

    // Sign-extend a stride to line-address width.
    function automatic logic [LADDR_BITS-1:0] stride_sext(input logic [STRIDE_BITS-1:0] s);
        return {{(LADDR_BITS-STRIDE_BITS){s[STRIDE_BITS-1]}}, s};
    endfunction

    // True when both line addresses fall in the same 4KB page.
    function automatic logic same_page(input logic [LADDR_BITS-1:0] a,
                                       input logic [LADDR_BITS-1:0] b);
        return a[LADDR_BITS-1:PF_PAGE_SHIFT] == b[LADDR_BITS-1:PF_PAGE_SHIFT];
    endfunction

endpackage

// File: rtl/pfgen_stride_tbl.sv
// Flop-based stride table: one combinational read port, one write port.
module pfgen_stride_tbl
    import pfgen_stride_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDXB    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXB-1:0] rd_idx_i,
    output pfgen_entry_t    rd_entry_c_o,
    input  logic            wr_en_i,
    input  logic [IDXB-1:0] wr_idx_i,
    input  pfgen_entry_t    wr_entry_i
);

    pfgen_entry_t tbl_q [ENTRIES];

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            tbl_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_c_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/pfgen_stride.sv
// PC-indexed stride prefetch generator feeding the prefetch engine.
module pfgen_stride
    import pfgen_stride_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CONF_THR = 2,
    parameter int unsigned DEGREE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  obs_valid,
    output logic                  obs_retry,
    input  logic [PC_BITS-1:0]    obs_pc,
    input  logic [LADDR_BITS-1:0] obs_laddr,
    input  logic                  pf_enable,
    output logic                  pfgtopfe_op_valid,
    input  logic                  pfgtopfe_op_retry,
    output I_pfgtopfe_op_type     pfgtopfe_op,
    output logic [15:0]           pf_issued
);

    localparam int unsigned IDXB     = $clog2(ENTRIES);
    localparam int unsigned TAG_LO   = IDXB + 2;
    localparam int unsigned CNT_BITS = 3;

    pfgen_state_e            state_q, state_d;
    I_pfgtopfe_op_type       op_q, op_d;
    logic                    op_valid_q, op_valid_d;
    logic [LADDR_BITS-1:0]   base_q, base_d;
    logic [STRIDE_BITS-1:0]  stride_q, stride_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [15:0]             issued_q, issued_d;

    logic [IDXB-1:0]           obs_idx;
    logic [PFGEN_TAG_BITS-1:0] obs_tag;
    pfgen_entry_t              rd_entry;
    pfgen_entry_t              tbl_wdata;
    logic                      tbl_we;
    logic                      hit;
    logic [LADDR_BITS-1:0]     delta;
    logic                      delta_fits;
    logic                      delta_is_stride;
    logic [CONF_BITS-1:0]      conf_next;
    logic [LADDR_BITS-1:0]     first_cand;
    logic [LADDR_BITS-1:0]     next_cand;
    logic                      obs_fire;
    logic                      op_fire;
    logic                      unused_pc_bits;

    assign obs_idx = obs_pc[IDXB+1:2];
    assign obs_tag = obs_pc[TAG_LO+PFGEN_TAG_BITS-1:TAG_LO];
    assign unused_pc_bits = ^{obs_pc[PC_BITS-1:TAG_LO+PFGEN_TAG_BITS], obs_pc[1:0]};

    pfgen_stride_tbl #(.ENTRIES(ENTRIES)) u_tbl (
        .clk          (clk),
        .reset        (reset),
        .rd_idx_i     (obs_idx),
        .rd_entry_c_o (rd_entry),
        .wr_en_i      (tbl_we),
        .wr_idx_i     (obs_idx),
        .wr_entry_i   (tbl_wdata)
    );

    // Lookup and training arithmetic on the observed line.
    assign hit             = rd_entry.valid && (rd_entry.tag == obs_tag);
    assign delta           = obs_laddr - rd_entry.last;
    assign delta_fits      = (&delta[LADDR_BITS-1:STRIDE_BITS-1]) | ~(|delta[LADDR_BITS-1:STRIDE_BITS-1]);
    assign delta_is_stride = (delta == stride_sext(rd_entry.stride));
    assign conf_next       = (rd_entry.conf == '1) ? rd_entry.conf : rd_entry.conf + CONF_BITS'(1);
    assign first_cand      = obs_laddr + stride_sext(rd_entry.stride);
    assign next_cand       = op_q.laddr + stride_sext(stride_q);
    assign obs_fire        = obs_valid && (state_q == ST_IDLE);
    assign op_fire         = op_valid_q && !pfgtopfe_op_retry;

    // Next-state: table training, burst launch and per-op advance.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_valid_d = op_valid_q;
        base_d     = base_q;
        stride_d   = stride_q;
        cnt_d      = cnt_q;
        issued_d   = issued_q;
        tbl_we     = 1'b0;
        tbl_wdata  = rd_entry;

        if (op_fire && (issued_q != 16'hFFFF)) begin
            issued_d = issued_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (obs_fire) begin
                    tbl_we = 1'b1;
                    if (!hit) begin
                        tbl_wdata.valid  = 1'b1;
                        tbl_wdata.tag    = obs_tag;
                        tbl_wdata.last   = obs_laddr;
                        tbl_wdata.stride = '0;
                        tbl_wdata.conf   = '0;
                    end else if (delta == '0) begin
                        tbl_we = 1'b0;
                    end else if (!delta_fits) begin
                        tbl_wdata.last   = obs_laddr;
                        tbl_wdata.stride = '0;
                        tbl_wdata.conf   = '0;
                    end else if (delta_is_stride) begin
                        tbl_wdata.last = obs_laddr;
                        tbl_wdata.conf = conf_next;
                        if (pf_enable && (conf_next >= CONF_BITS'(CONF_THR))
                            && same_page(first_cand, obs_laddr)) begin
                            op_d.laddr  = first_cand;
                            op_d.l2only = 1'b0;
                            op_valid_d  = 1'b1;
                            base_d      = obs_laddr;
                            stride_d    = rd_entry.stride;
                            cnt_d       = '0;
                            state_d     = ST_ISSUE;
                        end
                    end else begin
                        tbl_wdata.last   = obs_laddr;
                        tbl_wdata.stride = delta[STRIDE_BITS-1:0];
                        tbl_wdata.conf   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_fire) begin
                    if ((cnt_q + CNT_BITS'(1)) == CNT_BITS'(DEGREE)) begin
                        op_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (same_page(next_cand, base_q)) begin
                        op_d.laddr  = next_cand;
                        op_d.l2only = 1'b1;
                        cnt_d       = cnt_q + CNT_BITS'(1);
                    end else begin
                        op_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, output op flop and statistics counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
        end
    end

    assign obs_retry         = (state_q == ST_ISSUE);
    assign pfgtopfe_op_valid = op_valid_q;
    assign pfgtopfe_op       = op_q;
    assign pf_issued         = issued_q;

endmodule
